// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the functional units, wb_port_arbiter and the scoreboard writeback ports.
// The exception struct is declared here so both sides share one layout.
interface wb_port_arbiter_if #(
    parameter int NR_FU         = 4,
    parameter int NR_WB_PORTS   = 3,
    parameter int TRANS_ID_BITS = 2
);
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    logic [NR_FU-1:0]                          fu_valid_i;
    logic [NR_FU-1:0]                          fu_ready_o;
    logic [NR_FU-1:0][TRANS_ID_BITS-1:0]       fu_trans_id_i;
    logic [NR_FU-1:0][63:0]                    fu_result_i;
    exception_t [NR_FU-1:0]                    fu_ex_i;

    logic [NR_WB_PORTS-1:0]                    wb_valid_o;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [NR_WB_PORTS-1:0][63:0]              wb_result_o;
    exception_t [NR_WB_PORTS-1:0]              wb_ex_o;

    modport master (
        output fu_valid_i, fu_trans_id_i, fu_result_i, fu_ex_i,
        input  fu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_o
    );

    modport slave (
        input  fu_valid_i, fu_trans_id_i, fu_result_i, fu_ex_i,
        output fu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: one holding buffer per FU and round-robin grant of up to NR_WB_PORTS
// buffered results per cycle onto registered scoreboard writeback ports.
module wb_port_arbiter #(
    parameter int NR_FU         = 4,
    parameter int NR_WB_PORTS   = 3,
    parameter int TRANS_ID_BITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    wb_port_arbiter_if.slave bus
);
    localparam int FU_IDX_W = (NR_FU > 1) ? $clog2(NR_FU) : 1;
    localparam int EX_BITS  = 129;

    logic [NR_FU-1:0]                          buf_valid_q;
    logic [NR_FU-1:0][TRANS_ID_BITS-1:0]       buf_trans_id_q;
    logic [NR_FU-1:0][63:0]                    buf_result_q;
    logic [NR_FU-1:0][EX_BITS-1:0]             buf_ex_q;
    logic [FU_IDX_W-1:0]                       rr_q;
    logic [FU_IDX_W-1:0]                       rr_d;

    logic [NR_FU-1:0]                          grant;
    logic [NR_FU-1:0]                          fu_ready;
    logic [NR_FU-1:0]                          capture;
    logic                                      any_grant;
    logic [NR_WB_PORTS-1:0]                    port_en;
    logic [NR_WB_PORTS-1:0][FU_IDX_W-1:0]      port_sel;

    logic [NR_WB_PORTS-1:0]                    wb_valid_q;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_q;
    logic [NR_WB_PORTS-1:0][63:0]              wb_result_q;
    logic [NR_WB_PORTS-1:0][EX_BITS-1:0]       wb_ex_q;

    // Scan from rr_q; the k-th full buffer found goes to port k until the ports run out.
    always_comb begin
        logic [FU_IDX_W-1:0] idx;
        logic [FU_IDX_W-1:0] last;
        int                  n_granted;
        grant     = '0;
        port_en   = '0;
        port_sel  = '0;
        idx       = '0;
        last      = rr_q;
        n_granted = 0;
        for (int k = 0; k < NR_FU; k++) begin
            idx = FU_IDX_W'((int'(rr_q) + k) % NR_FU);
            if (buf_valid_q[idx] && (n_granted < NR_WB_PORTS)) begin
                grant[idx] = 1'b1;
                for (int p = 0; p < NR_WB_PORTS; p++) begin
                    if (p == n_granted) begin
                        port_en[p]  = 1'b1;
                        port_sel[p] = idx;
                    end
                end
                n_granted = n_granted + 1;
                last      = idx;
            end
        end
        any_grant = (n_granted != 0);
        rr_d      = FU_IDX_W'((int'(last) + 1) % NR_FU);
    end

    assign fu_ready       = ~buf_valid_q | grant;
    assign capture        = bus.fu_valid_i & fu_ready;
    assign bus.fu_ready_o = fu_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_q    <= '0;
            buf_trans_id_q <= '0;
            buf_result_q   <= '0;
            buf_ex_q       <= '0;
            rr_q           <= '0;
        end else if (flush_i) begin
            buf_valid_q <= '0;
        end else begin
            for (int i = 0; i < NR_FU; i++) begin
                if (capture[i]) begin
                    buf_valid_q[i]    <= 1'b1;
                    buf_trans_id_q[i] <= bus.fu_trans_id_i[i];
                    buf_result_q[i]   <= bus.fu_result_i[i];
                    buf_ex_q[i]       <= bus.fu_ex_i[i];
                end else if (grant[i]) begin
                    buf_valid_q[i] <= 1'b0;
                end
            end
            if (any_grant) begin
                rr_q <= rr_d;
            end
        end
    end

    // Unused ports keep their old data; only the valid bit drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q    <= '0;
            wb_trans_id_q <= '0;
            wb_result_q   <= '0;
            wb_ex_q       <= '0;
        end else if (flush_i) begin
            wb_valid_q <= '0;
        end else begin
            wb_valid_q <= port_en;
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (port_en[p]) begin
                    wb_trans_id_q[p] <= buf_trans_id_q[port_sel[p]];
                    wb_result_q[p]   <= buf_result_q[port_sel[p]];
                    wb_ex_q[p]       <= buf_ex_q[port_sel[p]];
                end
            end
        end
    end

    assign bus.wb_valid_o    = wb_valid_q;
    assign bus.wb_trans_id_o = wb_trans_id_q;
    assign bus.wb_result_o   = wb_result_q;
    assign bus.wb_ex_o       = wb_ex_q;

`ifndef SYNTHESIS
    logic dup_trans_id;

    always_comb begin
        dup_trans_id = 1'b0;
        for (int i = 0; i < NR_FU; i++) begin
            for (int j = i + 1; j < NR_FU; j++) begin
                if (buf_valid_q[i] && buf_valid_q[j] && (buf_trans_id_q[i] == buf_trans_id_q[j])) begin
                    dup_trans_id = 1'b1;
                end
            end
        end
    end

    a_unique_trans_id: assert property (@(posedge clk_i) disable iff (rst_i) !dup_trans_id);
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter: a queue-based reference model of the buffers and
// round-robin grants, plus directed scenarios with fixed expected values.
module tb_wb_port_arbiter;
    localparam int NR_FU         = 4;
    localparam int NR_WB_PORTS   = 3;
    localparam int TRANS_ID_BITS = 2;

    logic clk;
    logic rst;
    logic flush;

    wb_port_arbiter_if #(
        .NR_FU(NR_FU), .NR_WB_PORTS(NR_WB_PORTS), .TRANS_ID_BITS(TRANS_ID_BITS)
    ) bus ();

    wb_port_arbiter #(
        .NR_FU(NR_FU), .NR_WB_PORTS(NR_WB_PORTS), .TRANS_ID_BITS(TRANS_ID_BITS)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: which FU holds a result, and what each port should show next.
    bit           m_full [NR_FU];
    logic [1:0]   m_id   [NR_FU];
    logic [63:0]  m_res  [NR_FU];
    logic [128:0] m_ex   [NR_FU];
    int           m_rr;
    bit           e_valid[NR_WB_PORTS];
    logic [1:0]   e_id   [NR_WB_PORTS];
    logic [63:0]  e_res  [NR_WB_PORTS];
    logic [128:0] e_ex   [NR_WB_PORTS];

    logic [1:0]   drv_id [NR_FU];
    logic [63:0]  drv_res[NR_FU];
    logic [128:0] drv_ex [NR_FU];
    int           wb_count[NR_FU];

    task automatic checkOutput(input string tag, input logic [191:0] observed, input logic [191:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic randomData();
        for (int i = 0; i < NR_FU; i++) begin
            drv_id[i]  = 2'(i);
            drv_res[i] = {$urandom, $urandom};
            drv_ex[i]  = {$urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1))};
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR_FU; i++) m_full[i] = 1'b0;
        for (int p = 0; p < NR_WB_PORTS; p++) e_valid[p] = 1'b0;
        m_rr = 0;
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks the next edge.
    task automatic applyStimulus(input logic [3:0] valid, input logic fl);
        int         order[$];
        bit         granted[NR_FU];
        logic [3:0] exp_ready;
        for (int i = 0; i < NR_FU; i++) begin
            bus.fu_valid_i[i]    = valid[i];
            bus.fu_trans_id_i[i] = drv_id[i];
            bus.fu_result_i[i]   = drv_res[i];
            bus.fu_ex_i[i]       = drv_ex[i];
        end
        flush = fl;
        for (int k = 0; k < NR_FU; k++) begin
            int f;
            f = (m_rr + k) % NR_FU;
            if (m_full[f] && order.size() < NR_WB_PORTS) order.push_back(f);
        end
        for (int i = 0; i < NR_FU; i++) granted[i] = 1'b0;
        foreach (order[q]) granted[order[q]] = 1'b1;
        for (int i = 0; i < NR_FU; i++) exp_ready[i] = !m_full[i] || granted[i];
        #1;
        checkOutput("fu_ready", 192'(bus.fu_ready_o), 192'(exp_ready));

        if (fl) begin
            for (int i = 0; i < NR_FU; i++) m_full[i] = 1'b0;
            for (int p = 0; p < NR_WB_PORTS; p++) e_valid[p] = 1'b0;
        end else begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (p < order.size()) begin
                    e_valid[p] = 1'b1;
                    e_id[p]    = m_id[order[p]];
                    e_res[p]   = m_res[order[p]];
                    e_ex[p]    = m_ex[order[p]];
                end else begin
                    e_valid[p] = 1'b0;
                end
            end
            for (int i = 0; i < NR_FU; i++) begin
                if (valid[i] && exp_ready[i]) begin
                    m_full[i] = 1'b1;
                    m_id[i]   = drv_id[i];
                    m_res[i]  = drv_res[i];
                    m_ex[i]   = drv_ex[i];
                end else if (granted[i]) begin
                    m_full[i] = 1'b0;
                end
            end
            if (order.size() > 0) m_rr = (order[order.size() - 1] + 1) % NR_FU;
        end

        @(posedge clk);
        #1;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            checkOutput("wb_valid", 192'(bus.wb_valid_o[p]), 192'(e_valid[p]));
            if (e_valid[p]) begin
                checkOutput("wb_trans_id", 192'(bus.wb_trans_id_o[p]), 192'(e_id[p]));
                checkOutput("wb_result", 192'(bus.wb_result_o[p]), 192'(e_res[p]));
                checkOutput("wb_ex", 192'(bus.wb_ex_o[p]), 192'(e_ex[p]));
            end
            if (bus.wb_valid_o[p]) wb_count[bus.wb_trans_id_o[p]]++;
        end
    endtask

    // Asynchronous reset raised between edges; outputs must clear before any clock edge.
    task automatic doReset();
        bus.fu_valid_i = '0;
        flush = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_wb_valid", 192'(bus.wb_valid_o), 192'(0));
        checkOutput("rst_fu_ready", 192'(bus.fu_ready_o), 192'(4'hF));
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int rot[4][3] = '{'{0, 1, 2}, '{3, 0, 1}, '{2, 3, 0}, '{1, 2, 3}};

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        bus.fu_valid_i = '0;
        for (int i = 0; i < NR_FU; i++) wb_count[i] = 0;
        randomData();
        doReset();

        // Single request with fixed payload
        randomData();
        drv_id[1]  = 2'd2;
        drv_res[1] = 64'hDEAD;
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("single_valid", 192'(bus.wb_valid_o), 192'(3'b001));
        checkOutput("single_id", 192'(bus.wb_trans_id_o[0]), 192'(2));
        checkOutput("single_result", 192'(bus.wb_result_o[0]), 192'(64'hDEAD));
        applyStimulus(4'b0000, 1'b0);
        checkOutput("single_once", 192'(bus.wb_valid_o), 192'(3'b000));

        // Oversubscription from rr = 0
        doReset();
        randomData();
        applyStimulus(4'b1111, 1'b0);
        checkOutput("over_ready3", 192'(bus.fu_ready_o[3]), 192'(0));
        applyStimulus(4'b0000, 1'b0);
        checkOutput("over_valid1", 192'(bus.wb_valid_o), 192'(3'b111));
        for (int p = 0; p < NR_WB_PORTS; p++)
            checkOutput("over_port_fu", 192'(bus.wb_trans_id_o[p]), 192'(p));
        applyStimulus(4'b0000, 1'b0);
        checkOutput("over_valid2", 192'(bus.wb_valid_o), 192'(3'b001));
        checkOutput("over_fu3", 192'(bus.wb_trans_id_o[0]), 192'(3));
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("over_rr_wrap", 192'(bus.wb_trans_id_o[0]), 192'(0));

        // Fairness under continuous requests
        doReset();
        randomData();
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < NR_FU; i++) wb_count[i] = 0;
        for (int c = 0; c < 8; c++) begin
            randomData();
            applyStimulus(4'b1111, 1'b0);
            checkOutput("fair_valid", 192'(bus.wb_valid_o), 192'(3'b111));
            for (int p = 0; p < NR_WB_PORTS; p++)
                checkOutput("fair_rotation", 192'(bus.wb_trans_id_o[p]), 192'(rot[c % 4][p]));
        end
        for (int i = 0; i < NR_FU; i++)
            checkOutput("fair_count", 192'(wb_count[i]), 192'(6));

        // Flush with every buffer and port busy
        randomData();
        applyStimulus(4'b1111, 1'b1);
        checkOutput("flush_valid", 192'(bus.wb_valid_o), 192'(3'b000));
        checkOutput("flush_ready", 192'(bus.fu_ready_o), 192'(4'hF));
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput("flush_no_stale", 192'(bus.wb_valid_o), 192'(3'b000));
        end

        // Exception pass-through
        randomData();
        drv_id[0] = 2'd1;
        drv_ex[0] = {64'h5, 64'h1000, 1'b1};
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("ex_valid", 192'(bus.wb_valid_o), 192'(3'b001));
        checkOutput("ex_id", 192'(bus.wb_trans_id_o[0]), 192'(1));
        checkOutput("ex_payload", 192'(bus.wb_ex_o[0]), 192'({64'h5, 64'h1000, 1'b1}));

        // Random traffic with occasional flush and mid-run reset
        for (int c = 0; c < 400; c++) begin
            logic [3:0] v;
            randomData();
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) doReset();
            else applyStimulus(v, 1'($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end
endmodule
